// File: rtl/tdc_event_stamper.sv
// -----------------------------------------------------------------------------
// tdc_event_stamper
//
// Timestamps hit events from the TDC test path. Each rising edge of `hit`
// seen while armed captures the free-running coarse counter together with the
// delay-line thermometer snapshot. The snapshot is converted to a binary fine
// code one cycle later, and {coarse, fine} is pushed into a small output FIFO
// with a valid/ready interface. `clear` re-arms the capture logic between hits.
//
// Build option:
//   TDC_BUBBLE_CORRECT_EN  defined   : fine = saturated popcount of thermometer
//                          undefined : fine = highest set tap index + 1
//                                      (0 if none), saturated to TAPS-1
//
// Parameters:
//   COARSE_W   coarse counter width
//   TAPS       delay-line thermometer width
//   FINE_W     fine code width, must equal clog2(TAPS)
//   FIFO_DEPTH output FIFO entries, power of two >= 2
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   hit          synchronous hit strobe (rising edge is the event)
//   clear        synchronous re-arm strobe
//   fine_therm   thermometer snapshot, bit 0 is the earliest tap
//   out_valid    FIFO head is valid
//   out_ready    consumer accepts the head
//   out_data     {coarse, fine}, coarse in the MSBs; zero while empty
//   fifo_count   FIFO occupancy
//   overflow     sticky, set when a word is dropped on a full FIFO
//   missed_hits  saturating count of hit edges ignored while not armed
// -----------------------------------------------------------------------------
module tdc_event_stamper #(
    parameter int COARSE_W   = 16,
    parameter int TAPS       = 64,
    parameter int FINE_W     = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hit,
    input  logic                          clear,
    input  logic [TAPS-1:0]               fine_therm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COARSE_W+FINE_W-1:0]    out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    missed_hits
);

    localparam int DATA_W = COARSE_W + FINE_W;
    localparam int AW     = $clog2(FIFO_DEPTH);

    // Largest representable fine code, held one bit wider than the code so
    // that a full-scale count (TAPS) can be compared before saturation.
    localparam logic [FINE_W:0] FINE_MAX = (FINE_W + 1)'(TAPS - 1);

    typedef enum logic {
        ST_ARMED,
        ST_WAIT_CLEAR
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next_state;
    logic                  w_capture;
    logic                  w_miss;

    logic [COARSE_W-1:0]   r_coarse;
    logic                  r_hit_q;
    logic                  w_rise;

    logic                  r_s1_valid;
    logic [COARSE_W-1:0]   r_s1_coarse;
    logic [TAPS-1:0]       r_s1_therm;

    logic [FINE_W:0]       w_fine_wide;
    logic [FINE_W-1:0]     w_fine;

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic [7:0]            r_missed;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_drop;

    // -------------------------------------------------------------------------
    // Coarse counter and hit edge detect
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coarse <= '0;
            r_hit_q  <= 1'b0;
        end else begin
            r_coarse <= r_coarse + COARSE_W'(1);
            r_hit_q  <= hit;
        end
    end

    assign w_rise = hit & ~r_hit_q;

    // -------------------------------------------------------------------------
    // Arm / re-arm FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_miss       = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (w_rise) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_WAIT_CLEAR;
                end
            end
            ST_WAIT_CLEAR: begin
                // A hit coinciding with clear still counts as missed; the
                // clear wins for the state transition.
                if (w_rise) begin
                    w_miss = 1'b1;
                end
                if (clear) begin
                    w_next_state = ST_ARMED;
                end
            end
            default: begin
                w_next_state = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_missed <= '0;
        end else if (w_miss && (r_missed != 8'hFF)) begin
            r_missed <= r_missed + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Capture stage 1: coarse value (pre-increment) and thermometer snapshot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_coarse <= '0;
            r_s1_therm  <= '0;
        end else begin
            r_s1_valid <= w_capture;
            if (w_capture) begin
                r_s1_coarse <= r_coarse;
                r_s1_therm  <= fine_therm;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Capture stage 2: thermometer to binary conversion
    // -------------------------------------------------------------------------
`ifdef TDC_BUBBLE_CORRECT_EN
    // Popcount tolerates bubbles in the thermometer code.
    always_comb begin
        w_fine_wide = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            w_fine_wide = w_fine_wide + (FINE_W + 1)'(r_s1_therm[i]);
        end
    end
`else
    // Priority encoder on the highest set tap; the last match wins.
    always_comb begin
        w_fine_wide = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            if (r_s1_therm[i]) begin
                w_fine_wide = (FINE_W + 1)'(i + 1);
            end
        end
    end
`endif

    always_comb begin
        if (w_fine_wide > FINE_MAX) begin
            w_fine = FINE_MAX[FINE_W-1:0];
        end else begin
            w_fine = w_fine_wide[FINE_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    assign w_full    = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = r_s1_valid;
    assign w_pop     = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {r_s1_coarse, w_fine};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head storage is not reset, so the output is forced to zero while empty.
    assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign missed_hits = r_missed;

endmodule

// File: tb/tb_tdc_event_stamper.sv
module tb_tdc_event_stamper;

    logic        clk;
    logic        rst_n;
    logic        hit;
    logic        clear;
    logic [63:0] fine_therm;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  missed_hits;

    int checks;
    int errors;

    tdc_event_stamper #(
        .COARSE_W  (16),
        .TAPS      (64),
        .FINE_W    (6),
        .FIFO_DEPTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hit        (hit),
        .clear      (clear),
        .fine_therm (fine_therm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .missed_hits(missed_hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with reset released; the
    // next edge is the first one at which the coarse counter advances 0->1.
    task automatic do_reset();
        rst_n      = 1'b0;
        hit        = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        fine_therm = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        hit        = 1'b1;
        clear      = 1'b0;
        out_ready  = 1'b1;
        fine_therm = 64'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, fifo_count, overflow, missed_hits, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b cnt=%0d ovf=%b miss=%0d data=%h want all zero",
                     out_valid, fifo_count, overflow, missed_hits, out_data);
        end
        hit = 1'b0;
    endtask

    task automatic test_fine_code();
        do_reset();
        repeat (5) tick();
        hit        = 1'b1;
        fine_therm = 64'h0000_0000_0000_00FF;
        tick();
        hit = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fine_early_valid: got %b want %b", out_valid, 1'b0);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fine_valid: got %b want %b", out_valid, 1'b1);
        end
        checks++;
        if (out_data !== {16'd5, 6'd8}) begin
            errors++;
            $display("FAIL fine_data: got %h want %h", out_data, {16'd5, 6'd8});
        end
        checks++;
        if (fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL fine_count: got %0d want %0d", fifo_count, 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] words [16];
        int          nwords;
        do_reset();
        out_ready  = 1'b1;
        fine_therm = 64'h0F;
        nwords     = 0;
        repeat (2) tick();
        for (int i = 0; i < 23; i++) begin
            hit   = (i < 20) && (i % 2 == 0);
            clear = (i < 20) && (i % 2 == 1);
            tick();
            if (out_valid && nwords < 16) begin
                words[nwords] = out_data;
                nwords++;
            end
        end
        hit   = 1'b0;
        clear = 1'b0;
        checks++;
        if (nwords !== 10) begin
            errors++;
            $display("FAIL b2b_word_count: got %0d want %0d", nwords, 10);
        end
        for (int j = 0; j < 10 && j < nwords; j++) begin
            checks++;
            if (words[j] !== {16'(2 + 2 * j), 6'd4}) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h want %h", j, words[j], {16'(2 + 2 * j), 6'd4});
            end
        end
        checks++;
        if (missed_hits !== 8'd0) begin
            errors++;
            $display("FAIL b2b_missed: got %0d want %0d", missed_hits, 0);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_not_armed();
        do_reset();
        fine_therm = 64'h1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            hit = (i % 2 == 0);
            tick();
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data[21:6] !== 16'd3) begin
                    errors++;
                    $display("FAIL na_capture: got v=%b coarse=%0d want v=1 coarse=3",
                             out_valid, out_data[21:6]);
                end
            end
        end
        hit = 1'b0;
        checks++;
        if (fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL na_count: got %0d want %0d", fifo_count, 1);
        end
        checks++;
        if (missed_hits !== 8'd2) begin
            errors++;
            $display("FAIL na_missed: got %0d want %0d", missed_hits, 2);
        end
        // Rise and clear together: re-arm, count a miss, no capture.
        hit   = 1'b1;
        clear = 1'b1;
        tick();
        hit   = 1'b0;
        clear = 1'b0;
        tick();
        checks++;
        if (missed_hits !== 8'd3 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL na_rise_clear: got miss=%0d cnt=%0d want miss=3 cnt=1",
                     missed_hits, fifo_count);
        end
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 4'd2 || out_data[21:6] !== 16'd3) begin
            errors++;
            $display("FAIL na_rearmed: got cnt=%0d head=%0d want cnt=2 head=3",
                     fifo_count, out_data[21:6]);
        end
    endtask

    task automatic test_overflow();
        logic [21:0] words [16];
        int          nwords;
        logic [15:0] exp_coarse [8];
        exp_coarse = '{16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16, 16'd21};
        do_reset();
        fine_therm = 64'h1;
        repeat (2) tick();
        for (int i = 0; i < 18; i++) begin
            hit   = (i % 2 == 0);
            clear = (i % 2 == 1);
            tick();
        end
        hit   = 1'b0;
        clear = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL ovf_count: got %0d want %0d", fifo_count, 8);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b want %b", overflow, 1'b1);
        end
        checks++;
        if (out_data !== {16'd2, 6'd1}) begin
            errors++;
            $display("FAIL ovf_head: got %h want %h", out_data, {16'd2, 6'd1});
        end
        // Hit while full; its push lands on the same edge as a pop.
        hit = 1'b1;
        tick();
        hit       = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_push_pop: got cnt=%0d ovf=%b want cnt=8 ovf=1",
                     fifo_count, overflow);
        end
        nwords = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && nwords < 16) begin
                words[nwords] = out_data;
                nwords++;
            end
            tick();
        end
        checks++;
        if (nwords !== 8) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d want %0d", nwords, 8);
        end
        for (int j = 0; j < 8 && j < nwords; j++) begin
            checks++;
            if (words[j] !== {exp_coarse[j], 6'd1}) begin
                errors++;
                $display("FAIL ovf_word%0d: got %h want %h", j, words[j], {exp_coarse[j], 6'd1});
            end
        end
        checks++;
        if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got cnt=%0d v=%b want cnt=0 v=0", fifo_count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_bubble();
        logic [63:0] vecs [4];
        logic [5:0]  exp_fine [4];
        vecs = '{64'h0000_0000_0000_00F7, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000};
`ifdef TDC_BUBBLE_CORRECT_EN
        exp_fine = '{6'd7, 6'd63, 6'd0, 6'd1};
`else
        exp_fine = '{6'd8, 6'd63, 6'd0, 6'd63};
`endif
        do_reset();
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            hit        = 1'b1;
            fine_therm = vecs[k];
            tick();
            hit        = 1'b0;
            clear      = 1'b1;
            fine_therm = '0;
            tick();
            clear = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data[5:0] !== exp_fine[k]) begin
                errors++;
                $display("FAIL bubble_vec%0d: got v=%b fine=%0d want v=1 fine=%0d",
                         k, out_valid, out_data[5:0], exp_fine[k]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        fine_therm = 64'h3;
        repeat (3) tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, fifo_count, overflow, missed_hits, out_data} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got v=%b cnt=%0d ovf=%b miss=%0d data=%h want all zero",
                     out_valid, fifo_count, overflow, missed_hits, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL midrst_noword: got v=%b cnt=%0d want v=0 cnt=0", out_valid, fifo_count);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {16'd5, 6'd2}) begin
            errors++;
            $display("FAIL midrst_restart: got v=%b data=%h want v=1 data=%h",
                     out_valid, out_data, {16'd5, 6'd2});
        end
        checks++;
        if (fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL midrst_count: got %0d want %0d", fifo_count, 1);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        hit        = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        fine_therm = '0;
        test_reset();
        test_fine_code();
        test_back_to_back();
        test_not_armed();
        test_overflow();
        test_bubble();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
